// File: rtl/if_ctrl_pkg.sv
// Shared fetch-stage definitions: bus widths, reset vector, PC step and the
// sequencer state encoding used by if_ctrl.
package if_ctrl_pkg;

  localparam int unsigned IF_ADDR_W   = 32;
  localparam int unsigned IF_INST_W   = 32;
  localparam logic [31:0] IF_RESET_VEC = 32'h0000_0000;
  localparam int unsigned IF_PC_INC   = 4;

  typedef enum logic [1:0] {
    IF_BOOT = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_HOLD = 2'd3
  } if_state_e;

endpackage

// File: rtl/if_buf.sv
// Single-entry valid/ready instruction buffer between fetch and decode.
// A flush wins over both a load and a coincident decode handshake.
module if_buf
  import if_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = IF_ADDR_W,
  parameter int unsigned INST_W = IF_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              flush_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              free_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  // Empty now, or emptied by a drain or flush on this edge.
  assign free_o  = !valid_q || ready_i || flush_i;
  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_ctrl.sv
// Instruction-fetch sequencer: owns next_pc, issues one outstanding memory
// request at a time and hands fetched words to decode via if_buf.
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W    = IF_ADDR_W,
  parameter int unsigned       INST_W    = IF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(IF_RESET_VEC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [INST_W-1:0] mem_rdata,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  input  logic              id_ready,
  output logic              ce,
  output logic [ADDR_W-1:0] pc
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              discard_q, discard_d;
  logic              ce_q;
  logic [ADDR_W-1:0] pc_sel;
  logic              buf_load;
  logic              buf_free;

  // A redirect seen this cycle overrides the stored next_pc for any request
  // issued on the same edge.
  assign pc_sel = branch_valid ? branch_target : next_pc_q;

  always_comb begin
    state_d    = state_q;
    next_pc_d  = next_pc_q;
    req_addr_d = req_addr_q;
    discard_d  = discard_q;
    buf_load   = 1'b0;
    if (branch_valid) next_pc_d = branch_target;
    case (state_q)
      IF_BOOT: begin
        if (!stall) begin
          req_addr_d = pc_sel;
          state_d    = IF_REQ;
        end
      end
      IF_REQ: begin
        // mem_addr stays on req_addr until gnt; a redirect only marks the
        // in-flight word for dropping.
        if (branch_valid) discard_d = 1'b1;
        if (mem_gnt) begin
          state_d = IF_WAIT;
          if (!branch_valid && !discard_q)
            next_pc_d = req_addr_q + ADDR_W'(IF_PC_INC);
        end
      end
      IF_WAIT: begin
        if (mem_rvalid) begin
          if (discard_q || branch_valid) begin
            discard_d = 1'b0;
            if (stall) begin
              state_d = IF_HOLD;
            end else begin
              req_addr_d = pc_sel;
              state_d    = IF_REQ;
            end
          end else begin
            buf_load = 1'b1;
            state_d  = IF_HOLD;
          end
        end else if (branch_valid) begin
          discard_d = 1'b1;
        end
      end
      IF_HOLD: begin
        if (buf_free && !stall) begin
          req_addr_d = pc_sel;
          state_d    = IF_REQ;
        end
      end
      default: state_d = IF_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IF_BOOT;
      next_pc_q  <= RESET_VEC;
      req_addr_q <= RESET_VEC;
      discard_q  <= 1'b0;
      ce_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_pc_q  <= next_pc_d;
      req_addr_q <= req_addr_d;
      discard_q  <= discard_d;
      ce_q       <= 1'b1;
    end
  end

  if_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .pc_i    (req_addr_q),
    .inst_i  (mem_rdata),
    .flush_i (branch_valid),
    .ready_i (id_ready),
    .valid_o (id_valid),
    .pc_o    (id_pc),
    .inst_o  (id_inst),
    .free_o  (buf_free)
  );

  assign mem_req  = (state_q == IF_REQ);
  assign mem_addr = req_addr_q;
  assign ce       = ce_q;
  assign pc       = next_pc_q;

endmodule

// File: tb/tb_if_ctrl.sv
// Directed bench for if_ctrl with a one-cycle-latency instruction memory model.
module tb_if_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_ready;
  logic        ce;
  logic [31:0] pc;

  int          n_chk;
  int          n_fail;
  logic        pend;
  logic [31:0] paddr;
  int          hold_cnt;

  if_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_inst       (id_inst),
    .id_ready      (id_ready),
    .ce            (ce),
    .pc            (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock: memory accepts on req&&gnt, answers exactly one cycle later
  // with data = addr ^ 0xC0DE0000. Inputs change on the falling edge.
  task automatic step();
    logic        hs;
    logic [31:0] a;
    hs = mem_req && mem_gnt;
    a  = mem_addr;
    @(posedge clk);
    if (!rst) begin
      pend = 1'b0;
    end else begin
      pend = hs;
      if (hs) paddr = a;
    end
    @(negedge clk);
    mem_rvalid = pend;
    mem_rdata  = paddr ^ 32'hC0DE_0000;
    if (hold_cnt > 0) begin
      mem_gnt = 1'b0;
      hold_cnt--;
    end else begin
      mem_gnt = 1'b1;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0; pend = 1'b0; paddr = '0; hold_cnt = 0;
    rst = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; id_ready = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk1("rst_ce", ce, 1'b0);
    chk1("rst_req", mem_req, 1'b0);
    chk1("rst_idv", id_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_idpc", id_pc, 32'h0);
    chk("rst_idinst", id_inst, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);

    // Straight-line fetch, one word per three cycles.
    rst = 1'b1;
    chk1("boot_ce", ce, 1'b0);
    chk1("boot_req", mem_req, 1'b0);
    step();
    chk1("req0_ce", ce, 1'b1);
    chk1("req0_req", mem_req, 1'b1);
    chk("req0_addr", mem_addr, 32'h0);
    step();
    chk1("wait0_req", mem_req, 1'b0);
    chk("wait0_pc", pc, 32'h4);
    step();
    chk1("hold0_v", id_valid, 1'b1);
    chk("hold0_pc", id_pc, 32'h0);
    chk("hold0_inst", id_inst, 32'hC0DE_0000);
    step();
    chk1("req4_req", mem_req, 1'b1);
    chk("req4_addr", mem_addr, 32'h4);
    step(); step();
    chk1("hold4_v", id_valid, 1'b1);
    chk("hold4_pc", id_pc, 32'h4);

    // Decode back-pressure for five cycles.
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("bp_v", id_valid, 1'b1);
      chk("bp_pc", id_pc, 32'h4);
      chk("bp_inst", id_inst, 32'hC0DE_0004);
      chk1("bp_req", mem_req, 1'b0);
      chk("bp_npc", pc, 32'h8);
    end
    id_ready = 1'b1;
    step();
    chk1("req8_req", mem_req, 1'b1);
    chk("req8_addr", mem_addr, 32'h8);
    chk1("req8_v", id_valid, 1'b0);

    // Redirect in WAIT: the 0x8 response is dropped.
    step();
    chk1("wait8_req", mem_req, 1'b0);
    branch_valid = 1'b1; branch_target = 32'h100;
    step();
    branch_valid = 1'b0;
    chk1("br1_v", id_valid, 1'b0);
    chk1("br1_req", mem_req, 1'b1);
    chk("br1_addr", mem_addr, 32'h100);
    chk("br1_pc", pc, 32'h100);
    step(); step();
    chk1("br1_hold_v", id_valid, 1'b1);
    chk("br1_hold_pc", id_pc, 32'h100);
    chk("br1_hold_inst", id_inst, 32'hC0DE_0100);

    // Grant withheld four cycles, redirect to 0x40 in the second one.
    mem_gnt = 1'b0; hold_cnt = 4;
    step();
    chk1("ng_req", mem_req, 1'b1);
    chk("ng_addr1", mem_addr, 32'h104);
    step();
    branch_valid = 1'b1; branch_target = 32'h40;
    step();
    branch_valid = 1'b0;
    chk("ng_addr3", mem_addr, 32'h104);
    chk1("ng_req3", mem_req, 1'b1);
    chk("ng_pc3", pc, 32'h40);
    step();
    chk("ng_addr4", mem_addr, 32'h104);
    step();
    chk1("ng_gnt_req", mem_req, 1'b1);
    step();
    chk1("ng_wait_req", mem_req, 1'b0);
    chk("ng_wait_pc", pc, 32'h40);
    step();
    chk1("br2_req", mem_req, 1'b1);
    chk("br2_addr", mem_addr, 32'h40);
    chk1("br2_v", id_valid, 1'b0);
    step(); step();
    chk1("br2_hold_v", id_valid, 1'b1);
    chk("br2_hold_pc", id_pc, 32'h40);
    chk("br2_hold_inst", id_inst, 32'hC0DE_0040);

    // Stall across an outstanding fetch, then stall together with a redirect.
    step();
    chk("st_addr", mem_addr, 32'h44);
    stall = 1'b1;
    chk1("st_req_kept", mem_req, 1'b1);
    step();
    chk1("st_wait_req", mem_req, 1'b0);
    step();
    chk1("st_fill_v", id_valid, 1'b1);
    chk("st_fill_pc", id_pc, 32'h44);
    step();
    chk1("st_drain_v", id_valid, 1'b0);
    chk1("st_drain_req", mem_req, 1'b0);
    branch_valid = 1'b1; branch_target = 32'h20;
    step();
    branch_valid = 1'b0;
    chk1("stbr_req", mem_req, 1'b0);
    chk("stbr_pc", pc, 32'h20);
    step();
    chk1("stbr_req2", mem_req, 1'b0);
    stall = 1'b0;
    step();
    chk1("stbr_rel_req", mem_req, 1'b1);
    chk("stbr_rel_addr", mem_addr, 32'h20);
    step();
    chk1("pre_rst_req", mem_req, 1'b0);
    chk("pre_rst_pc", pc, 32'h24);

    // Asynchronous reset in the middle of WAIT.
    #2 rst = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk1("arst_ce", ce, 1'b0);
    chk1("arst_req", mem_req, 1'b0);
    chk1("arst_v", id_valid, 1'b0);
    step();
    chk1("arst_hold_ce", ce, 1'b0);
    rst = 1'b1;
    chk1("reboot_req", mem_req, 1'b0);
    step();
    chk1("reboot_req1", mem_req, 1'b1);
    chk("reboot_addr", mem_addr, 32'h0);
    step();
    chk("reboot_pc", pc, 32'h4);
    step();
    chk1("reboot_v", id_valid, 1'b1);
    chk("reboot_idpc", id_pc, 32'h0);

    // Redirect from HOLD to the top of the address space; PC+4 wraps to 0.
    branch_valid = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    branch_valid = 1'b0;
    chk1("wrap_flush_v", id_valid, 1'b0);
    chk1("wrap_req", mem_req, 1'b1);
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc, 32'h0);
    step();
    chk("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_inst", id_inst, 32'h3F21_FFFC);
    step();
    chk("wrap_next_addr", mem_addr, 32'h0);
    chk1("wrap_next_req", mem_req, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
